hazard_ctrl: RTL

//  Drives the control side of the pipeline registers: enables (en_i) and flushes for F/D/E/M/W.

---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, control flush, E-stage forwarding select,
// and whole-pipeline freeze while a data-memory access in M waits for ready.
module hazard_ctrl #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH              = 32,
  parameter int MAX_WAIT               = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemAccessM_i,
  input  logic                              dmem_ready_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              EnE_o,
  output logic                              EnM_o,
  output logic                              EnW_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              dmem_req_o,
  output logic                              mem_timeout_o,
  output logic [CNT_WIDTH-1:0]              stall_cnt_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                miss_start;
  logic                frozen;
  logic                load_use;

  // A miss freezes combinationally in its first cycle, before the FSM has moved.
  assign miss_start = (state_q == RUN) && MemAccessM_i && !dmem_ready_i;
  assign frozen     = !rst_i && (miss_start || ((state_q == MEM_WAIT) && !dmem_ready_i));
  assign load_use   = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (miss_start)   state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready_i) state_d = RUN;
      default:                    state_d = RUN;
    endcase
  end

  always_comb begin
    StallF_o   = 1'b0;
    StallD_o   = 1'b0;
    FlushD_o   = 1'b0;
    FlushE_o   = 1'b0;
    EnE_o      = 1'b1;
    EnM_o      = 1'b1;
    EnW_o      = 1'b1;
    dmem_req_o = 1'b0;
    if (rst_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else begin
      dmem_req_o = (state_q == MEM_WAIT) || MemAccessM_i;
      if (frozen) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        EnE_o    = 1'b0;
        EnM_o    = 1'b0;
        EnW_o    = 1'b0;
      end else if (PCSrcE_i) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (load_use) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
  end

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))      ForwardAE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i)) ForwardAE_o = 2'b01;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))      ForwardBE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i)) ForwardBE_o = 2'b01;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      state_q <= state_d;
      if (frozen) begin
        if (wait_cnt_q != WAIT_W'(MAX_WAIT)) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q >= WAIT_W'(MAX_WAIT - 1)) mem_timeout_o <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
      if (StallF_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule
